// File: rtl/micro_pkg.sv
// Shared definitions for the microcode sequencer: control-word layout,
// sequencing codes, micro-state numbering and the opcodes it dispatches on.
package micro_pkg;

  localparam int WORD_W = 17;

  localparam int F_BRANCH     = 16;
  localparam int F_PC_UPDATE  = 15;
  localparam int F_REG_WRITE  = 14;
  localparam int F_MEM_WRITE  = 13;
  localparam int F_IR_WRITE   = 12;
  localparam int F_ADR_SRC    = 11;
  localparam int F_RESULT_LO  = 9;
  localparam int F_SRC_A_LO   = 7;
  localparam int F_SRC_B_LO   = 5;
  localparam int F_ALU_OP_LO  = 3;
  localparam int F_SEQ_LO     = 0;

  localparam logic [2:0] SEQ_NEXT  = 3'b000;
  localparam logic [2:0] SEQ_DISP1 = 3'b001;
  localparam logic [2:0] SEQ_DISP2 = 3'b010;
  localparam logic [2:0] SEQ_FETCH = 3'b011;
  localparam logic [2:0] SEQ_ALUWB = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } ustate_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic       branch;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] seq;
  } ctrl_word_t;

endpackage

// File: rtl/microsequencer_if.sv
// Bundle of the sequencer's ROM, datapath-control and status signals.
interface microsequencer_if
  import micro_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int UADDR_W = 4
);
  logic [6:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic [WORD_W-1:0]  rom_word;
  logic [UADDR_W-1:0] rom_addr;
  logic               pc_write;
  logic               reg_write;
  logic               mem_write;
  logic               ir_write;
  logic               adr_src;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [CNT_W-1:0]   retired;
  logic               illegal_op;
  logic               seq_error;

  modport master (
    output opcode, zero, mem_ready, rom_word,
    input  rom_addr, pc_write, reg_write, mem_write, ir_write, adr_src,
    input  result_src, alu_src_a, alu_src_b, alu_op, retired, illegal_op, seq_error
  );

  modport slave (
    input  opcode, zero, mem_ready, rom_word,
    output rom_addr, pc_write, reg_write, mem_write, ir_write, adr_src,
    output result_src, alu_src_a, alu_src_b, alu_op, retired, illegal_op, seq_error
  );
endinterface

// File: rtl/microsequencer_dispatch_rom.sv
// Opcode-indexed jump table for both decode dispatches; flags opcodes the
// core does not implement.
module dispatch_rom
  import micro_pkg::*;
#(
  parameter int UADDR_W = 4
) (
  input  logic [6:0]         opcode,
  output logic [UADDR_W-1:0] disp1_target,
  output logic [UADDR_W-1:0] disp2_target,
  output logic               illegal
);

  always_comb begin
    disp1_target = UADDR_W'(S_FETCH);
    disp2_target = UADDR_W'(S_FETCH);
    illegal      = 1'b0;
    case (opcode)
      OP_LW: begin
        disp1_target = UADDR_W'(S_MEMADR);
        disp2_target = UADDR_W'(S_MEMREAD);
      end
      OP_SW: begin
        disp1_target = UADDR_W'(S_MEMADR);
        disp2_target = UADDR_W'(S_MEMWRITE);
      end
      OP_R:    disp1_target = UADDR_W'(S_EXECR);
      OP_I:    disp1_target = UADDR_W'(S_EXECI);
      OP_JAL:  disp1_target = UADDR_W'(S_JAL);
      OP_BEQ:  disp1_target = UADDR_W'(S_BEQ);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Micro-PC, control-word unpacking and next-address logic for the multicycle
// RISC-V control store; also counts retired instructions.
module microsequencer
  import micro_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int UADDR_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  microsequencer_if.slave  bus
);

  ctrl_word_t         word;
  logic [UADDR_W-1:0] upc;
  logic [UADDR_W-1:0] next_upc;
  logic [UADDR_W-1:0] disp1_target;
  logic [UADDR_W-1:0] disp2_target;
  logic               disp_illegal;
  logic               mem_state;
  logic               stall;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q;
  logic               seq_error_q;

  assign word = ctrl_word_t'(bus.rom_word);

  dispatch_rom #(.UADDR_W(UADDR_W)) u_dispatch (
    .opcode       (bus.opcode),
    .disp1_target (disp1_target),
    .disp2_target (disp2_target),
    .illegal      (disp_illegal)
  );

  // Only the three memory-access states wait on mem_ready.
  assign mem_state = (upc == UADDR_W'(S_FETCH))
                  || (upc == UADDR_W'(S_MEMREAD))
                  || (upc == UADDR_W'(S_MEMWRITE));
  assign stall     = mem_state && !bus.mem_ready;

  always_comb begin
    next_upc = UADDR_W'(S_FETCH);
    case (word.seq)
      SEQ_NEXT:  next_upc = upc + 1'b1;
      SEQ_DISP1: next_upc = disp1_target;
      SEQ_DISP2: next_upc = disp2_target;
      SEQ_FETCH: next_upc = UADDR_W'(S_FETCH);
      SEQ_ALUWB: next_upc = UADDR_W'(S_ALUWB);
      default:   next_upc = UADDR_W'(S_FETCH);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc         <= UADDR_W'(S_FETCH);
      retired_q   <= '0;
      illegal_q   <= 1'b0;
      seq_error_q <= 1'b0;
    end else if (!stall) begin
      upc <= next_upc;
      if (word.seq == SEQ_FETCH)
        retired_q <= retired_q + 1'b1;
      if (word.seq == SEQ_DISP1 && disp_illegal)
        illegal_q <= 1'b1;
      if (word.seq > SEQ_ALUWB)
        seq_error_q <= 1'b1;
    end
  end

  // Architectural-state strobes are suppressed during stalls and reset;
  // mem_write must persist so a pending store stays on the bus.
  assign bus.rom_addr   = upc;
  assign bus.pc_write   = reset_n && !stall && (word.pc_update || (word.branch && bus.zero));
  assign bus.reg_write  = reset_n && !stall && word.reg_write;
  assign bus.ir_write   = reset_n && !stall && word.ir_write;
  assign bus.mem_write  = word.mem_write;
  assign bus.adr_src    = word.adr_src;
  assign bus.result_src = word.result_src;
  assign bus.alu_src_a  = word.alu_src_a;
  assign bus.alu_src_b  = word.alu_src_b;
  assign bus.alu_op     = word.alu_op;
  assign bus.retired    = retired_q;
  assign bus.illegal_op = illegal_q;
  assign bus.seq_error  = seq_error_q;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench: a small microcode ROM drives the sequencer through
// directed instruction sequences and checks each cycle's outputs.
module tb_microsequencer;
  import micro_pkg::*;

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic [3:0]  strobes;
    logic [31:0] retired;
    logic        ill;
    logic        serr;
  } exp_t;

  logic clk;
  logic reset_n;
  logic force_seq;
  logic [WORD_W-1:0] rom_val;
  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  microsequencer_if #(.CNT_W(32), .UADDR_W(4)) bus ();

  microsequencer #(.CNT_W(32), .UADDR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Classic multicycle RISC-V microprogram.
  function automatic ctrl_word_t rom_lookup(input logic [3:0] a);
    ctrl_word_t c;
    c = '0;
    case (a)
      4'd0: begin c.ir_write = 1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1; c.seq = SEQ_NEXT; end
      4'd1: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.seq = SEQ_DISP1; end
      4'd2: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.seq = SEQ_DISP2; end
      4'd3: begin c.adr_src = 1; c.seq = SEQ_NEXT; end
      4'd4: begin c.result_src = 2'b01; c.reg_write = 1; c.seq = SEQ_FETCH; end
      4'd5: begin c.adr_src = 1; c.mem_write = 1; c.seq = SEQ_FETCH; end
      4'd6: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; c.seq = SEQ_ALUWB; end
      4'd7: begin c.reg_write = 1; c.seq = SEQ_FETCH; end
      4'd8: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; c.seq = SEQ_ALUWB; end
      4'd9: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1; c.seq = SEQ_ALUWB; end
      4'd10: begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1; c.seq = SEQ_FETCH; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    rom_val = rom_lookup(bus.rom_addr);
    if (force_seq)
      rom_val[2:0] = 3'b110;
    bus.rom_word = rom_val;
  end

  task automatic checkOutput(input exp_t e);
    logic [3:0] act;
    act = {bus.pc_write, bus.reg_write, bus.mem_write, bus.ir_write};
    vectors++;
    if (bus.rom_addr !== e.addr || act !== e.strobes || bus.retired !== e.retired
        || bus.illegal_op !== e.ill || bus.seq_error !== e.serr) begin
      miscompares++;
      $display("[TB] FAIL %s: got addr=%0d pc/reg/mem/ir=%b retired=%0d ill=%b serr=%b, expected addr=%0d pc/reg/mem/ir=%b retired=%0d ill=%b serr=%b",
               e.name, bus.rom_addr, act, bus.retired, bus.illegal_op, bus.seq_error,
               e.addr, e.strobes, e.retired, e.ill, e.serr);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Drives one cycle's inputs (called just after a rising edge) and queues
  // the outputs expected for that cycle.
  task automatic applyStimulus(input string name, input logic rst, input logic [6:0] op,
                               input logic z, input logic rdy, input logic fseq,
                               input logic [3:0] addr, input logic [3:0] strobes,
                               input int ret, input logic ill, input logic serr);
    exp_t e;
    reset_n       = rst;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    force_seq     = fseq;
    e.name = name; e.addr = addr; e.strobes = strobes;
    e.retired = 32'(ret); e.ill = ill; e.serr = serr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    force_seq     = 1'b0;
    bus.opcode    = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("reset",     0, OP_R, 0, 1, 0, 4'd0, 4'b0000, 0, 0, 0);

    applyStimulus("r_fetch",   1, OP_R, 0, 1, 0, 4'd0, 4'b1001, 0, 0, 0);
    applyStimulus("r_decode",  1, OP_R, 0, 1, 0, 4'd1, 4'b0000, 0, 0, 0);
    applyStimulus("r_exec",    1, OP_R, 0, 1, 0, 4'd6, 4'b0000, 0, 0, 0);
    applyStimulus("r_aluwb",   1, OP_R, 0, 1, 0, 4'd7, 4'b0100, 0, 0, 0);

    applyStimulus("lw_fetch",  1, OP_LW, 0, 1, 0, 4'd0, 4'b1001, 1, 0, 0);
    applyStimulus("lw_decode", 1, OP_LW, 0, 1, 0, 4'd1, 4'b0000, 1, 0, 0);
    applyStimulus("lw_adr",    1, OP_LW, 0, 1, 0, 4'd2, 4'b0000, 1, 0, 0);
    applyStimulus("lw_wait1",  1, OP_LW, 0, 0, 0, 4'd3, 4'b0000, 1, 0, 0);
    applyStimulus("lw_wait2",  1, OP_LW, 0, 0, 0, 4'd3, 4'b0000, 1, 0, 0);
    applyStimulus("lw_read",   1, OP_LW, 0, 1, 0, 4'd3, 4'b0000, 1, 0, 0);
    applyStimulus("lw_wb",     1, OP_LW, 0, 1, 0, 4'd4, 4'b0100, 1, 0, 0);

    applyStimulus("sw_fetch",  1, OP_SW, 0, 1, 0, 4'd0, 4'b1001, 2, 0, 0);
    applyStimulus("sw_decode", 1, OP_SW, 0, 1, 0, 4'd1, 4'b0000, 2, 0, 0);
    applyStimulus("sw_adr",    1, OP_SW, 0, 1, 0, 4'd2, 4'b0000, 2, 0, 0);
    applyStimulus("sw_wait",   1, OP_SW, 0, 0, 0, 4'd5, 4'b0010, 2, 0, 0);
    applyStimulus("sw_write",  1, OP_SW, 0, 1, 0, 4'd5, 4'b0010, 2, 0, 0);

    applyStimulus("beq1_fstall", 1, OP_BEQ, 1, 0, 0, 4'd0, 4'b0000, 3, 0, 0);
    applyStimulus("beq1_fetch",  1, OP_BEQ, 1, 1, 0, 4'd0, 4'b1001, 3, 0, 0);
    applyStimulus("beq1_decode", 1, OP_BEQ, 1, 0, 0, 4'd1, 4'b0000, 3, 0, 0);
    applyStimulus("beq1_taken",  1, OP_BEQ, 1, 0, 0, 4'd10, 4'b1000, 3, 0, 0);
    applyStimulus("beq0_fetch",  1, OP_BEQ, 0, 1, 0, 4'd0, 4'b1001, 4, 0, 0);
    applyStimulus("beq0_decode", 1, OP_BEQ, 0, 1, 0, 4'd1, 4'b0000, 4, 0, 0);
    applyStimulus("beq0_ntaken", 1, OP_BEQ, 0, 1, 0, 4'd10, 4'b0000, 4, 0, 0);

    applyStimulus("i_fetch",   1, OP_I, 0, 1, 0, 4'd0, 4'b1001, 5, 0, 0);
    applyStimulus("i_decode",  1, OP_I, 0, 1, 0, 4'd1, 4'b0000, 5, 0, 0);
    applyStimulus("i_exec",    1, OP_I, 0, 1, 0, 4'd8, 4'b0000, 5, 0, 0);
    applyStimulus("i_aluwb",   1, OP_I, 0, 1, 0, 4'd7, 4'b0100, 5, 0, 0);

    applyStimulus("jal_fetch", 1, OP_JAL, 0, 1, 0, 4'd0, 4'b1001, 6, 0, 0);
    applyStimulus("jal_decode",1, OP_JAL, 0, 1, 0, 4'd1, 4'b0000, 6, 0, 0);
    applyStimulus("jal_jump",  1, OP_JAL, 0, 1, 0, 4'd9, 4'b1000, 6, 0, 0);
    applyStimulus("jal_aluwb", 1, OP_JAL, 0, 1, 0, 4'd7, 4'b0100, 6, 0, 0);

    applyStimulus("ill_fetch", 1, 7'b1111111, 0, 1, 0, 4'd0, 4'b1001, 7, 0, 0);
    applyStimulus("ill_decode",1, 7'b1111111, 0, 1, 0, 4'd1, 4'b0000, 7, 0, 0);
    applyStimulus("ill_refetch",1, OP_R, 0, 1, 0, 4'd0, 4'b1001, 7, 1, 0);
    applyStimulus("ill_decode2",1, OP_R, 0, 1, 0, 4'd1, 4'b0000, 7, 1, 0);
    applyStimulus("ill_exec",  1, OP_R, 0, 1, 0, 4'd6, 4'b0000, 7, 1, 0);
    applyStimulus("ill_aluwb", 1, OP_R, 0, 1, 0, 4'd7, 4'b0100, 7, 1, 0);

    applyStimulus("serr_fetch",  1, OP_R, 0, 1, 0, 4'd0, 4'b1001, 8, 1, 0);
    applyStimulus("serr_forced", 1, OP_R, 0, 1, 1, 4'd1, 4'b0000, 8, 1, 0);
    applyStimulus("serr_refetch",1, OP_LW, 0, 1, 0, 4'd0, 4'b1001, 8, 1, 1);

    applyStimulus("ar_decode", 1, OP_LW, 0, 1, 0, 4'd1, 4'b0000, 8, 1, 1);
    applyStimulus("ar_adr",    1, OP_LW, 0, 1, 0, 4'd2, 4'b0000, 8, 1, 1);
    applyStimulus("ar_stall",  1, OP_LW, 0, 0, 0, 4'd3, 4'b0000, 8, 1, 1);
    applyStimulus("ar_reset",  0, OP_LW, 0, 0, 0, 4'd0, 4'b0000, 0, 0, 0);
    applyStimulus("ar_fetch",  1, OP_LW, 0, 1, 0, 4'd0, 4'b1001, 0, 0, 0);
    applyStimulus("ar_decode2",1, OP_LW, 0, 1, 0, 4'd1, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
